// File: rtl/mem_stage_pkg.sv
// Shared field layout for the EX/MEM and MEM/WB pipeline bundles of the memory stage.
package mem_stage_pkg;

  localparam int unsigned EX_MEM_W   = 71;
  localparam int unsigned MEM_WB_W   = 20;
  localparam int unsigned MEM_AW_DEF = 12;
  localparam int unsigned MEM_DW_DEF = 16;

  // EX/MEM bundle
  localparam int unsigned EX_RSVD_BIT = 70;
  localparam int unsigned EX_ADDR_MSB = 69;
  localparam int unsigned EX_ADDR_LSB = 38;
  localparam int unsigned EX_WB_BIT   = 37;
  localparam int unsigned EX_MW_BIT   = 36;
  localparam int unsigned EX_MR_BIT   = 35;
  localparam int unsigned EX_RDST_MSB = 34;
  localparam int unsigned EX_RDST_LSB = 32;
  localparam int unsigned EX_DATA_MSB = 31;
  localparam int unsigned EX_DATA_LSB = 0;

  // MEM/WB bundle
  localparam int unsigned WB_EN_BIT   = 19;
  localparam int unsigned WB_RDST_MSB = 18;
  localparam int unsigned WB_RDST_LSB = 16;
  localparam int unsigned WB_DATA_MSB = 15;
  localparam int unsigned WB_DATA_LSB = 0;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory: falling-edge write, combinational read, contents never reset.
module data_mem #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned MEM_DW = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [MEM_DW-1:0] wdata,
  output logic [MEM_DW-1:0] rdata
);

  logic [MEM_DW-1:0] r_mem [2**MEM_AW];

  // Mid-cycle write so the same cycle's read sees the new value before the next rising edge.
  always_ff @(negedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data memory access, writeback mux and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEF,
  parameter int unsigned MEM_DW = MEM_DW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [EX_MEM_W-1:0] ex_mem_in,
  output logic [MEM_WB_W-1:0] mem_out
);

  logic [EX_MEM_W-1:0] r_ex_mem;
  logic [MEM_WB_W-1:0] r_mem_out;
  logic [MEM_WB_W-1:0] w_mem_wb;
  logic [MEM_AW-1:0]   w_idx;
  logic [MEM_DW-1:0]   w_wdata;
  logic [MEM_DW-1:0]   w_rdata;
  logic                w_mw;
  logic                w_mr;
  logic                w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_mem <= '0;
    end else begin
      r_ex_mem <= ex_mem_in;
    end
  end

  // Upper address bits are dropped, so addresses alias modulo the memory depth.
  assign w_idx   = r_ex_mem[EX_ADDR_LSB +: MEM_AW];
  assign w_wdata = r_ex_mem[EX_DATA_LSB +: MEM_DW];
  assign w_mw    = r_ex_mem[EX_MW_BIT];
  assign w_mr    = r_ex_mem[EX_MR_BIT];

  assign w_unused = ^{r_ex_mem[EX_RSVD_BIT],
                      r_ex_mem[EX_ADDR_MSB:EX_ADDR_LSB+MEM_AW],
                      r_ex_mem[EX_DATA_MSB:EX_DATA_LSB+MEM_DW]};

  data_mem #(
    .MEM_AW (MEM_AW),
    .MEM_DW (MEM_DW)
  ) u_data_mem (
    .clk   (clk),
    .we    (w_mw),
    .addr  (w_idx),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  always_comb begin
    w_mem_wb = '0;
    w_mem_wb[WB_EN_BIT]               = r_ex_mem[EX_WB_BIT];
    w_mem_wb[WB_RDST_MSB:WB_RDST_LSB] = r_ex_mem[EX_RDST_MSB:EX_RDST_LSB];
    w_mem_wb[WB_DATA_MSB:WB_DATA_LSB] = w_mr ? w_rdata : w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_out <= '0;
    end else begin
      r_mem_out <= w_mem_wb;
    end
  end

  assign mem_out = r_mem_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed MEM/WB bundles.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [EX_MEM_W-1:0] ex_mem_in;
  logic [MEM_WB_W-1:0] mem_out;

  int unsigned n_checks;
  int unsigned n_pass;

  mem_stage u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_mem_in (ex_mem_in),
    .mem_out   (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EX_MEM_W-1:0] mk(input logic [31:0] addr, input logic wb,
                                             input logic mw, input logic mr,
                                             input logic [2:0] rdst, input logic [31:0] data);
    return {1'b0, addr, wb, mw, mr, rdst, data};
  endfunction

  task automatic check(input string tag, input logic [MEM_WB_W-1:0] got,
                       input logic [MEM_WB_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one bundle just after a rising edge, then sample its result two edges later.
  task automatic send(input logic [EX_MEM_W-1:0] b, input string tag,
                      input logic [MEM_WB_W-1:0] exp);
    ex_mem_in = b;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, mem_out, exp);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    ex_mem_in = '0;
    #2;
    check("reset_state", mem_out, 20'h00000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", mem_out, 20'h00000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(mk(32'h41554555, 1'b0, 1'b1, 1'b0, 3'd6, 32'h5D5545D7), "store",        20'h645D7);
    send(mk(32'h41554555, 1'b0, 1'b0, 1'b1, 3'd6, 32'h41554555), "load",         20'h645D7);
    send(mk(32'h41554555, 1'b1, 1'b0, 1'b0, 3'd6, 32'h415545D5), "alu_pass",     20'hE45D5);
    send(mk(32'h41554555, 1'b0, 1'b0, 1'b1, 3'd6, 32'h00000000), "load_again",   20'h645D7);
    send(mk(32'h000007FF, 1'b0, 1'b1, 1'b0, 3'd3, 32'hFFFFA5A5), "store_top",    20'h3A5A5);
    send(mk(32'h000007FF, 1'b1, 1'b0, 1'b1, 3'd1, 32'h00000000), "load_top",     20'h9A5A5);
    send(mk(32'h00000000, 1'b0, 1'b1, 1'b0, 3'd0, 32'h00000001), "store_zero",   20'h00001);
    send(mk(32'h00000000, 1'b1, 1'b0, 1'b1, 3'd7, 32'h0000FFFF), "load_zero",    20'hF0001);

    // Back-to-back store then load of the same word.
    ex_mem_in = mk(32'h00000020, 1'b0, 1'b1, 1'b0, 3'd2, 32'h00001111);
    @(posedge clk);
    #1;
    ex_mem_in = mk(32'h00000020, 1'b1, 1'b0, 1'b1, 3'd5, 32'h00000000);
    @(posedge clk);
    #1;
    check("stream_store", mem_out, 20'h21111);
    @(posedge clk);
    #1;
    check("stream_load", mem_out, 20'hD1111);

    // Asynchronous reset mid-cycle; a store presented during reset must not land.
    send(mk(32'h00000100, 1'b1, 1'b0, 1'b0, 3'd4, 32'h00002222), "pre_reset",    20'hC2222);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", mem_out, 20'h00000);
    ex_mem_in = mk(32'h00000555, 1'b1, 1'b1, 1'b0, 3'd6, 32'h0000DEAD);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_out", mem_out, 20'h00000);
    ex_mem_in = mk(32'h00000555, 1'b0, 1'b0, 1'b1, 3'd6, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post_reset_load", mem_out, 20'h645D7);
    @(posedge clk);
    #1;

    send(mk(32'h00001555, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0000BEEF), "wrap_store",   20'h1BEEF);
    send(mk(32'hFFFF0555, 1'b1, 1'b0, 1'b1, 3'd2, 32'h00000000), "wrap_load",    20'hABEEF);
    send(mk(32'h00000010, 1'b1, 1'b1, 1'b1, 3'd3, 32'h00001234), "rw_same",      20'hB1234);
    send(mk(32'h00000010, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000FFFF), "rw_readback",  20'h01234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage pipelined processor.
- Registers the 71-bit EX/MEM bundle from execute.
- Performs a data-memory read or write.
- Selects memory data or ALU data for writeback.
- Registers a 20-bit MEM/WB bundle for the writeback stage.

Parameters:
MEM_AW, 12, number of low address bits used to index data memory (depth 2^MEM_AW words).
MEM_DW, 16, data memory word width.

Ports:
clk  in  1  system clock; all registers update on rising edge.
rst_n  in  1  asynchronous, active-low reset.
ex_mem_in  in  71  EX/MEM bundle from execute stage.
mem_out  out  20  MEM/WB bundle to writeback stage.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- ex_mem_in field map:
  - [70] reserved, ignored.
  - [69:38] address (32b).
  - [37] wb_en (register write enable).
  - [36] mw (memory write).
  - [35] mr (memory read).
  - [34:32] rdst (destination register).
  - [31:0] data (ALU result / store data).
- mem_out field map:
  - [19] wb_en.
  - [18:16] rdst.
  - [15:0] wb_data.
- Stage 1 (EX/MEM register): ex_mem_q <= ex_mem_in on each rising edge; no enable, no stall.
- Data memory:
  - 2^MEM_AW x 16-bit array, indexed by ex_mem_q address[MEM_AW-1:0].
  - Upper address bits are ignored, so addresses wrap modulo the depth.
  - Write occurs on the falling edge of clk when mw=1: mem[idx] <= data[15:0]. This is mid-cycle, after the rising-edge capture into ex_mem_q.
  - Read is combinational on mem[idx].
  - data[31:16] is never stored.
- Writeback mux (combinational):
  - wb_data = mem[idx] when mr=1, else data[15:0].
  - mw has no effect on the mux.
- Stage 2 (MEM/WB register): mem_out <= {wb_en, rdst, wb_data} on each rising edge.
- Latency: a bundle sampled at rising edge k appears on mem_out after rising edge k+1 (2 edges).
- mw=1 and mr=1 together: the write happens at the falling edge, and mem_out captures the newly written value.
- mw=0: memory is unchanged; the read still happens if mr=1.
- Reset (rst_n=0):
  - ex_mem_q and mem_out clear to 0 immediately; while reset is held, mem_out reads 0.
  - Writes are inhibited because the cleared ex_mem_q has mw=0.
  - Memory contents are not cleared and persist across reset. Reading a never-written word returns X; the bench must write before reading.
- Reset released mid-stream: the first valid mem_out appears 2 rising edges after the first post-reset capture.

Decomposition:
- Shared package mem_stage_pkg:
  - Bit-position localparams for every ex_mem_in and mem_out field.
  - EX_MEM_W=71 and MEM_WB_W=20.
  - MEM_AW/MEM_DW defaults.
  - Optional packed struct typedefs for both bundles.
- One sub-module, data_mem: falling-edge-write, async-read RAM with ports clk, we, addr, wdata, rdata.
- The pipeline registers and the writeback mux stay in mem_stage.

Test Plan:
- Store: ex_mem_in={0,0x41554555,wb=0,mw=1,mr=0,rdst=6,0x5D5545D7} -> mem[0x555]=0x45D7; mem_out=0x645D7 (wb=0, rdst=6, data 0x45D7) two edges later.
- Load after store: same address, mw=0, mr=1, rdst=6, data=0x41554555 -> mem_out=0x645D7 (read data, not the ALU low half 0x4555).
- ALU pass-through: wb=1, mw=0, mr=0, rdst=6, data=0x415545D5 -> mem_out=0xE45D5; mem[0x555] still 0x45D7.
- Address wrap: store 0xBEEF at address 0x00001555, then load from address 0xFFFF0555 -> mem_out data=0xBEEF.
- Simultaneous mw=mr=1: address 0x10, data 0x1234 -> mem_out data=0x1234 (new value).
- Reset: assert rst_n=0 mid-stream -> mem_out=0 asynchronously; after release, previously stored 0x45D7 at 0x555 still reads back.
